wdma_writer: RTL and testbench

AXI4 write-DMA master. It drains a 64-bit output-feature-map stream from the compute core and writes it to DDR as INCR bursts, starting at base_addr and running linearly for total_beats beats. Bursts never cross a 4 KB boundary. The block tracks outstanding write responses and signals completion only after every B response has returned. It is the write-side counterpart of the feature-map read DMA and sits between the post-processing/maxpool output and the HP write port.

---
 rtl/wdma_writer_if.sv | 44 ++++
 rtl/wdma_writer.sv | 183 ++++++++++++++++++
 tb/tb_wdma_writer.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wdma_writer_if.sv
// AXI4 write-channel bundle (AW, W, B) between the write DMA and the HP port.
// The DMA side uses the master modport; the memory/interconnect side uses slave.
interface wdma_writer_if;
  logic        axi_wdma_AWVALID;
  logic        axi_wdma_AWREADY;
  logic [31:0] axi_wdma_AWADDR;
  logic [7:0]  axi_wdma_AWLEN;
  logic        axi_wdma_AWID;
  logic [2:0]  axi_wdma_AWSIZE;
  logic [1:0]  axi_wdma_AWBURST;
  logic [1:0]  axi_wdma_AWLOCK;
  logic [3:0]  axi_wdma_AWCACHE;
  logic [2:0]  axi_wdma_AWPROT;
  logic [3:0]  axi_wdma_AWQOS;
  logic        axi_wdma_WVALID;
  logic        axi_wdma_WREADY;
  logic [63:0] axi_wdma_WDATA;
  logic [7:0]  axi_wdma_WSTRB;
  logic        axi_wdma_WLAST;
  logic        axi_wdma_BVALID;
  logic        axi_wdma_BREADY;
  logic [1:0]  axi_wdma_BRESP;
  logic        axi_wdma_BID;

  modport master (
    output axi_wdma_AWVALID, axi_wdma_AWADDR, axi_wdma_AWLEN, axi_wdma_AWID,
           axi_wdma_AWSIZE, axi_wdma_AWBURST, axi_wdma_AWLOCK, axi_wdma_AWCACHE,
           axi_wdma_AWPROT, axi_wdma_AWQOS,
           axi_wdma_WVALID, axi_wdma_WDATA, axi_wdma_WSTRB, axi_wdma_WLAST,
           axi_wdma_BREADY,
    input  axi_wdma_AWREADY, axi_wdma_WREADY, axi_wdma_BVALID, axi_wdma_BRESP,
           axi_wdma_BID
  );

  modport slave (
    input  axi_wdma_AWVALID, axi_wdma_AWADDR, axi_wdma_AWLEN, axi_wdma_AWID,
           axi_wdma_AWSIZE, axi_wdma_AWBURST, axi_wdma_AWLOCK, axi_wdma_AWCACHE,
           axi_wdma_AWPROT, axi_wdma_AWQOS,
           axi_wdma_WVALID, axi_wdma_WDATA, axi_wdma_WSTRB, axi_wdma_WLAST,
           axi_wdma_BREADY,
    output axi_wdma_AWREADY, axi_wdma_WREADY, axi_wdma_BVALID, axi_wdma_BRESP,
           axi_wdma_BID
  );
endinterface

// File: rtl/wdma_writer.sv
// AXI4 write-DMA master: drains the 64-bit output-feature-map stream into DDR
// as INCR bursts that never cross a 4 KB page, tracks outstanding B responses
// and raises done only once every response has come back.
module wdma_writer #(
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ap_start,
  input  logic [31:0]         base_addr,
  input  logic [19:0]         total_beats,
  input  logic [63:0]         wdma_data,
  input  logic                wdma_valid,
  output logic                wdma_ready,
  output logic                wdma_done,
  output logic                wdma_error,
  wdma_writer_if.master       axi
);

  localparam int          OW         = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [19:0] MAX_BURST_W = 20'(MAX_BURST);
  localparam logic [OW-1:0] MAX_OUT_W = OW'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_AW, S_W, S_WAIT_B, S_DONE
  } state_t;

  state_t        r_state;
  logic [31:0]   r_addr;
  logic [19:0]   r_remaining;
  logic [19:0]   r_len;
  logic [19:0]   r_beat_cnt;
  logic [7:0]    r_awlen;
  logic [OW-1:0] r_outstanding;
  logic          r_start_d;
  logic          r_awvalid;
  logic          r_bready;
  logic          r_done;
  logic          r_error;

  logic          w_start_edge;
  logic          w_in_w;
  logic          w_wvalid;
  logic          w_aw_hs;
  logic          w_w_hs;
  logic          w_b_hs;
  logic          w_wlast;
  logic [12:0]   w_room;
  logic [19:0]   w_beats_4k;
  logic [19:0]   w_len;
  logic [OW-1:0] w_out_next;
  logic          w_unused;

  assign w_start_edge = ap_start & ~r_start_d;
  assign w_in_w       = (r_state == S_W);
  assign w_wvalid     = w_in_w & wdma_valid;
  assign w_aw_hs      = r_awvalid & axi.axi_wdma_AWREADY;
  assign w_w_hs       = w_wvalid & axi.axi_wdma_WREADY;
  assign w_b_hs       = axi.axi_wdma_BVALID & r_bready;
  assign w_wlast      = w_in_w & (r_beat_cnt == r_len - 20'd1);

  // Beats left before the next 4 KB page boundary (1..512).
  assign w_room     = 13'd4096 - {1'b0, r_addr[11:0]};
  assign w_beats_4k = {10'd0, w_room[12:3]};

  // Burst length = min(MAX_BURST, remaining, beats to page boundary).
  always_comb begin
    w_len = MAX_BURST_W;
    if (r_remaining < w_len) w_len = r_remaining;
    if (w_beats_4k < w_len)  w_len = w_beats_4k;
  end

  // Outstanding-burst count: AW adds, B removes, a stray B saturates at zero.
  always_comb begin
    w_out_next = r_outstanding;
    if (w_aw_hs && !w_b_hs) begin
      w_out_next = r_outstanding + OW'(1);
    end else if (!w_aw_hs && w_b_hs && (r_outstanding != '0)) begin
      w_out_next = r_outstanding - OW'(1);
    end
  end

  // Transfer FSM with registered AW/handshake/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_remaining   <= '0;
      r_len         <= '0;
      r_beat_cnt    <= '0;
      r_awlen       <= '0;
      r_outstanding <= '0;
      r_start_d     <= 1'b0;
      r_awvalid     <= 1'b0;
      r_bready      <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_start_d     <= ap_start;
      r_bready      <= 1'b1;
      r_outstanding <= w_out_next;
      if (w_b_hs && (axi.axi_wdma_BRESP != 2'b00)) r_error <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            r_addr      <= base_addr;
            r_remaining <= total_beats;
            r_error     <= 1'b0;
            if (total_beats == 20'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_len   <= w_len;
          r_awlen <= 8'(w_len - 20'd1);
          if (r_outstanding != MAX_OUT_W) begin
            r_awvalid <= 1'b1;
            r_state   <= S_AW;
          end
        end
        S_AW: begin
          if (w_aw_hs) begin
            r_awvalid  <= 1'b0;
            r_beat_cnt <= '0;
            r_state    <= S_W;
          end
        end
        S_W: begin
          if (w_w_hs) begin
            r_beat_cnt <= r_beat_cnt + 20'd1;
            if (w_wlast) begin
              r_addr      <= r_addr + (32'(r_len) << 3);
              r_remaining <= r_remaining - r_len;
              r_state     <= (r_remaining != r_len) ? S_CALC : S_WAIT_B;
            end
          end
        end
        S_WAIT_B: begin
          if (w_out_next == '0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          if (!ap_start) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_unused = axi.axi_wdma_BID;

  assign wdma_ready = w_in_w & axi.axi_wdma_WREADY;
  assign wdma_done  = r_done;
  assign wdma_error = r_error;

  assign axi.axi_wdma_AWVALID = r_awvalid;
  assign axi.axi_wdma_AWADDR  = r_addr;
  assign axi.axi_wdma_AWLEN   = r_awlen;
  assign axi.axi_wdma_AWID    = 1'b0;
  assign axi.axi_wdma_AWSIZE  = 3'b011;
  assign axi.axi_wdma_AWBURST = 2'b01;
  assign axi.axi_wdma_AWLOCK  = 2'b00;
  assign axi.axi_wdma_AWCACHE = 4'b0000;
  assign axi.axi_wdma_AWPROT  = 3'b000;
  assign axi.axi_wdma_AWQOS   = 4'b0000;
  assign axi.axi_wdma_WVALID  = w_wvalid;
  assign axi.axi_wdma_WDATA   = wdma_data;
  assign axi.axi_wdma_WSTRB   = 8'hFF;
  assign axi.axi_wdma_WLAST   = w_wlast;
  assign axi.axi_wdma_BREADY  = r_bready;

endmodule

// File: tb/tb_wdma_writer.sv
// Directed bench for wdma_writer: a small AXI slave model answers AW/W/B,
// a monitor logs every handshake, and each test compares the log against
// hand-computed burst addresses, lengths and WLAST positions.
`timescale 1ns/1ps
module tb_wdma_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ap_start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [19:0] total_beats = '0;
  logic [63:0] wdma_data;
  logic        wdma_valid;
  logic        wdma_ready;
  logic        wdma_done;
  logic        wdma_error;

  wdma_writer_if axi();

  wdma_writer #(.MAX_BURST(16), .MAX_OUTSTANDING(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .ap_start    (ap_start),
    .base_addr   (base_addr),
    .total_beats (total_beats),
    .wdma_data   (wdma_data),
    .wdma_valid  (wdma_valid),
    .wdma_ready  (wdma_ready),
    .wdma_done   (wdma_done),
    .wdma_error  (wdma_error),
    .axi         (axi.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Monitor log (written only by the monitor process).
  logic [31:0] aw_addr_q[$];
  logic [7:0]  aw_len_q[$];
  int          last_q[$];
  int          beat_cnt  = 0;
  int          wlast_cnt = 0;
  int          b_cnt     = 0;

  // Slave-model controls (written only by the test process).
  bit bp      = 1'b0;
  int b_limit = 32'h3FFF_FFFF;
  int b_drop  = 0;
  int err_at  = -1;

  // Snapshots taken at the start of each test.
  int aw0, bt0, lq0, b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave driver: updates inputs 2 ns after each rising edge.
  initial begin
    int pend;
    axi.axi_wdma_AWREADY = 1'b0;
    axi.axi_wdma_WREADY  = 1'b0;
    axi.axi_wdma_BVALID  = 1'b0;
    axi.axi_wdma_BRESP   = 2'b00;
    axi.axi_wdma_BID     = 1'b0;
    wdma_valid = 1'b0;
    wdma_data  = '0;
    forever begin
      @(posedge clk); #2;
      pend = wlast_cnt - b_cnt - b_drop;
      axi.axi_wdma_BVALID  = (pend > 0) && (b_cnt < b_limit);
      axi.axi_wdma_BRESP   = (b_cnt + 1 == err_at) ? 2'b10 : 2'b00;
      axi.axi_wdma_AWREADY = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      axi.axi_wdma_WREADY  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      wdma_valid           = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      wdma_data            = {32'hD0D0_0000, 32'(beat_cnt)};
    end
  end

  // Monitor: samples handshakes on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (axi.axi_wdma_AWVALID && axi.axi_wdma_AWREADY) begin
          aw_addr_q.push_back(axi.axi_wdma_AWADDR);
          aw_len_q.push_back(axi.axi_wdma_AWLEN);
        end
        if (axi.axi_wdma_WVALID && axi.axi_wdma_WREADY) begin
          beat_cnt++;
          if (axi.axi_wdma_WLAST) begin
            last_q.push_back(beat_cnt);
            wlast_cnt++;
          end
        end
        if (axi.axi_wdma_BVALID && axi.axi_wdma_BREADY) b_cnt++;
      end
    end
  end

  task automatic snap();
    aw0 = aw_addr_q.size();
    bt0 = beat_cnt;
    lq0 = last_q.size();
    b0  = b_cnt;
  endtask

  task automatic chk_aw(input string tag, input int i, input logic [31:0] a, input logic [7:0] l);
    if (aw0 + i < aw_addr_q.size()) begin
      chk({tag, "_addr"}, aw_addr_q[aw0 + i], a);
      chk({tag, "_len"}, aw_len_q[aw0 + i], l);
    end else begin
      chk({tag, "_present"}, aw_addr_q.size() - aw0, i + 1);
    end
  endtask

  task automatic chk_last(input string tag, input int i, input int pos);
    if (lq0 + i < last_q.size()) chk(tag, last_q[lq0 + i] - bt0, pos);
    else chk({tag, "_present"}, last_q.size() - lq0, i + 1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_awvalid"}, axi.axi_wdma_AWVALID, 0);
    chk({tag, "_awaddr"},  axi.axi_wdma_AWADDR, 0);
    chk({tag, "_awlen"},   axi.axi_wdma_AWLEN, 0);
    chk({tag, "_wvalid"},  axi.axi_wdma_WVALID, 0);
    chk({tag, "_wlast"},   axi.axi_wdma_WLAST, 0);
    chk({tag, "_ready"},   wdma_ready, 0);
    chk({tag, "_bready"},  axi.axi_wdma_BREADY, 0);
    chk({tag, "_done"},    wdma_done, 0);
    chk({tag, "_error"},   wdma_error, 0);
    chk({tag, "_consts"},
        {axi.axi_wdma_AWID, axi.axi_wdma_AWSIZE, axi.axi_wdma_AWBURST, axi.axi_wdma_AWLOCK,
         axi.axi_wdma_AWCACHE, axi.axi_wdma_AWPROT, axi.axi_wdma_AWQOS, axi.axi_wdma_WSTRB},
        {1'b0, 3'b011, 2'b01, 2'b00, 4'h0, 3'b000, 4'h0, 8'hFF});
  endtask

  task automatic start_xfer(input logic [31:0] a, input logic [19:0] n);
    base_addr   = a;
    total_beats = n;
    ap_start    = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int k = 0;
    while (wdma_done !== 1'b1 && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done"}, wdma_done, 1);
  endtask

  task automatic finish_xfer(input string tag);
    @(posedge clk); #2;
    ap_start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_done_clr"}, wdma_done, 0);
    @(posedge clk); #2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, required finish before 2 ms");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    // Reset state
    @(posedge clk); #1;
    chk_reset("rst0");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #2;
    chk("bready_after_rst", axi.axi_wdma_BREADY, 1);

    // T1: two full bursts, 2-cycle start latency
    snap();
    start_xfer(32'h1000_0000, 20'd32);
    @(posedge clk); #1;
    chk("t1_lat_p1", axi.axi_wdma_AWVALID, 0);
    @(posedge clk); #1;
    chk("t1_lat_p2", axi.axi_wdma_AWVALID, 1);
    wait_done("t1", 300);
    chk("t1_b_at_done", b_cnt - b0, 2);
    chk("t1_aw_cnt", aw_addr_q.size() - aw0, 2);
    chk_aw("t1_aw0", 0, 32'h1000_0000, 8'd15);
    chk_aw("t1_aw1", 1, 32'h1000_0080, 8'd15);
    chk_last("t1_last0", 0, 16);
    chk_last("t1_last1", 1, 32);
    chk("t1_beats", beat_cnt - bt0, 32);
    chk("t1_error", wdma_error, 0);
    finish_xfer("t1");

    // T2: 4 KB boundary split
    snap();
    start_xfer(32'h0000_0FC0, 20'd16);
    wait_done("t2", 300);
    chk("t2_aw_cnt", aw_addr_q.size() - aw0, 2);
    chk_aw("t2_aw0", 0, 32'h0000_0FC0, 8'd7);
    chk_aw("t2_aw1", 1, 32'h0000_1000, 8'd7);
    chk_last("t2_last0", 0, 8);
    chk_last("t2_last1", 1, 16);
    finish_xfer("t2");

    // T3: short single burst
    snap();
    start_xfer(32'h2000_0008, 20'd5);
    wait_done("t3", 200);
    chk("t3_aw_cnt", aw_addr_q.size() - aw0, 1);
    chk_aw("t3_aw0", 0, 32'h2000_0008, 8'd4);
    chk_last("t3_last0", 0, 5);
    finish_xfer("t3");

    // T4: outstanding limit with B withheld
    snap();
    b_limit = b_cnt;
    start_xfer(32'h3000_0000, 20'd96);
    repeat (150) @(negedge clk);
    chk("t4_aw_stall", aw_addr_q.size() - aw0, 4);
    chk("t4_beats_stall", beat_cnt - bt0, 64);
    chk("t4_no_done", wdma_done, 0);
    @(posedge clk); #2;
    b_limit = b_cnt + 1;
    repeat (60) @(negedge clk);
    chk("t4_aw_after1b", aw_addr_q.size() - aw0, 5);
    chk("t4_no_done2", wdma_done, 0);
    @(posedge clk); #2;
    b_limit = 32'h3FFF_FFFF;
    wait_done("t4", 300);
    chk("t4_aw_cnt", aw_addr_q.size() - aw0, 6);
    chk("t4_b_at_done", b_cnt - b0, 6);
    chk_aw("t4_aw4", 4, 32'h3000_0200, 8'd15);
    chk_aw("t4_aw5", 5, 32'h3000_0280, 8'd15);
    finish_xfer("t4");

    // T5: error response on the second B
    snap();
    err_at = b_cnt + 2;
    start_xfer(32'h0000_0000, 20'd24);
    wait_done("t5", 300);
    chk("t5_error", wdma_error, 1);
    chk_aw("t5_aw1", 1, 32'h0000_0080, 8'd7);
    finish_xfer("t5");
    err_at = -1;
    repeat (5) @(posedge clk);
    #1 chk("t5_error_sticky", wdma_error, 1);
    @(posedge clk); #2;

    // T6: next start clears error
    snap();
    start_xfer(32'h5000_0000, 20'd3);
    @(posedge clk); #1;
    chk("t6_error_clr", wdma_error, 0);
    wait_done("t6", 200);
    chk_aw("t6_aw0", 0, 32'h5000_0000, 8'd2);
    chk_last("t6_last0", 0, 3);
    chk("t6_error", wdma_error, 0);
    finish_xfer("t6");

    // T7: zero-length transfer
    snap();
    start_xfer(32'h7000_0000, 20'd0);
    wait_done("t7", 10);
    chk("t7_aw_cnt", aw_addr_q.size() - aw0, 0);
    finish_xfer("t7");

    // T8: back-pressure, reset mid-burst, then a clean transfer
    snap();
    bp = 1'b1;
    start_xfer(32'h6000_0000, 20'd40);
    k = 0;
    while ((beat_cnt - bt0) < 10 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("t8_progress", (beat_cnt - bt0) >= 10, 1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1 chk_reset("t8_rst");
    ap_start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    b_drop = wlast_cnt - b_cnt;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    snap();
    start_xfer(32'h0000_0F00, 20'd40);
    wait_done("t8", 3000);
    chk("t8_aw_cnt", aw_addr_q.size() - aw0, 3);
    chk_aw("t8_aw0", 0, 32'h0000_0F00, 8'd15);
    chk_aw("t8_aw1", 1, 32'h0000_0F80, 8'd15);
    chk_aw("t8_aw2", 2, 32'h0000_1000, 8'd7);
    chk_last("t8_last0", 0, 16);
    chk_last("t8_last1", 1, 32);
    chk_last("t8_last2", 2, 40);
    chk("t8_beats", beat_cnt - bt0, 40);
    bp = 1'b0;
    finish_xfer("t8");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
